// File: rtl/mem_arb_pkg.sv
// Shared types for the matrix RAM arbiter: requester ids, FSM states,
// read tag format and small id helpers used by the arbiter and tag pipe.
package mem_arb_pkg;

   localparam int NUM_REQ = 3;

   typedef logic [1:0] req_id_t;

   localparam req_id_t REQ_IN   = 2'd0;
   localparam req_id_t REQ_DISP = 2'd1;
   localparam req_id_t REQ_CALC = 2'd2;
   localparam req_id_t REQ_NONE = 2'd3;

   typedef enum logic {
      ARB    = 1'b0,
      LOCKED = 1'b1
   } arb_state_e;

   typedef struct packed {
      logic    vld;
      req_id_t id;
   } rd_tag_t;

   function automatic req_id_t rr_next(input req_id_t id);
      return (id == REQ_CALC) ? REQ_IN : req_id_t'(id + 2'd1);
   endfunction

   function automatic logic [NUM_REQ-1:0] id_onehot(input req_id_t id);
      logic [NUM_REQ-1:0] oh;
      oh = '0;
      case (id)
         REQ_IN:   oh = 3'b001;
         REQ_DISP: oh = 3'b010;
         REQ_CALC: oh = 3'b100;
         default:  oh = 3'b000;
      endcase
      return oh;
   endfunction

endpackage

// File: rtl/matrix_mem_arbiter_if.sv
// Bundle of the three requester ports, the RAM port and status outputs.
// slave: arbiter side; master: requesters + RAM + observer side.
interface matrix_mem_arbiter_if
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32
);
   logic              req_in, req_disp, req_calc;
   logic              we_in, we_disp, we_calc;
   logic [ADDR_W-1:0] addr_in, addr_disp, addr_calc;
   logic [DATA_W-1:0] wdata_in, wdata_calc;
   logic              lock_in, lock_disp, lock_calc;
   logic              gnt_in, gnt_disp, gnt_calc;
   logic              rvalid_in, rvalid_disp, rvalid_calc;
   logic [DATA_W-1:0] rdata;
   logic              mem_en, mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              err_oor, err_lock_to;
   req_id_t           arb_owner;

   modport slave (
      input  req_in, req_disp, req_calc,
      input  we_in, we_disp, we_calc,
      input  addr_in, addr_disp, addr_calc,
      input  wdata_in, wdata_calc,
      input  lock_in, lock_disp, lock_calc,
      input  mem_rdata,
      output gnt_in, gnt_disp, gnt_calc,
      output rvalid_in, rvalid_disp, rvalid_calc,
      output rdata,
      output mem_en, mem_we, mem_addr, mem_wdata,
      output err_oor, err_lock_to, arb_owner
   );

   modport master (
      output req_in, req_disp, req_calc,
      output we_in, we_disp, we_calc,
      output addr_in, addr_disp, addr_calc,
      output wdata_in, wdata_calc,
      output lock_in, lock_disp, lock_calc,
      output mem_rdata,
      input  gnt_in, gnt_disp, gnt_calc,
      input  rvalid_in, rvalid_disp, rvalid_calc,
      input  rdata,
      input  mem_en, mem_we, mem_addr, mem_wdata,
      input  err_oor, err_lock_to, arb_owner
   );

endinterface

// File: rtl/mem_arb_rd_tag_pipe.sv
// Read tag shift register, RD_LAT+1 deep; on exit registers RAM data
// into rdata and pulses the one-hot rvalid of the originating requester.
module mem_arb_rd_tag_pipe
   import mem_arb_pkg::*;
#(
   parameter int RD_LAT = 1,
   parameter int DATA_W = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               push,
   input  req_id_t            push_id,
   input  logic [DATA_W-1:0]  mem_rdata,
   output logic [NUM_REQ-1:0] rvalid,
   output logic [DATA_W-1:0]  rdata
);

   rd_tag_t tag_q [RD_LAT+1];
   rd_tag_t tag_out;

   assign tag_out = tag_q[RD_LAT];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i <= RD_LAT; i++) begin
            tag_q[i] <= '0;
         end
         rvalid <= '0;
         rdata  <= '0;
      end else begin
         tag_q[0] <= '{vld: push, id: push_id};
         for (int i = 1; i <= RD_LAT; i++) begin
            tag_q[i] <= tag_q[i-1];
         end
         rvalid <= tag_out.vld ? id_onehot(tag_out.id) : '0;
         if (tag_out.vld) begin
            rdata <= mem_rdata;
         end
      end
   end

endmodule

// File: rtl/matrix_mem_arbiter.sv
// Round-robin arbiter with burst lock for the shared matrix RAM.
// Ports: clk, rst_n, bus (slave: requesters, RAM port, status).
module matrix_mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W    = 8,
   parameter int DATA_W    = 32,
   parameter int MEM_DEPTH = 256,
   parameter int RD_LAT    = 1,
   parameter int LOCK_MAX  = 1023
) (
   input logic                  clk,
   input logic                  rst_n,
   matrix_mem_arbiter_if.slave  bus
);

   localparam int CNT_W = $clog2(LOCK_MAX + 1);

   logic [NUM_REQ-1:0] req, lock;

   arb_state_e         state_q, state_d;
   req_id_t            rr_q, rr_d;
   req_id_t            owner_q, owner_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [NUM_REQ-1:0] blk_q, blk_d;
   req_id_t            sel, cand, gnt_id;
   logic               to_d;

   logic [NUM_REQ-1:0] gnt_q, gnt_d;
   logic               en_q, en_d;
   logic               we_q, we_d;
   logic [ADDR_W-1:0]  addr_q, addr_d;
   logic [DATA_W-1:0]  wdata_q, wdata_d;
   logic               oor_q, oor_d;
   logic               to_q;
   logic               push;

   logic [ADDR_W-1:0]  sel_addr;
   logic [DATA_W-1:0]  sel_wdata;
   logic               sel_we;

   logic [NUM_REQ-1:0] rvalid;
   logic               unused_we_disp;

   // display only reads; its write enable is intentionally dropped
   assign unused_we_disp = bus.we_disp;

   assign req  = {bus.req_calc, bus.req_disp, bus.req_in};
   assign lock = {bus.lock_calc, bus.lock_disp, bus.lock_in};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ARB;
         rr_q    <= REQ_IN;
         owner_q <= REQ_NONE;
         cnt_q   <= '0;
         blk_q   <= '0;
         gnt_q   <= '0;
         en_q    <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         oor_q   <= 1'b0;
         to_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         rr_q    <= rr_d;
         owner_q <= owner_d;
         cnt_q   <= cnt_d;
         blk_q   <= blk_d;
         gnt_q   <= gnt_d;
         en_q    <= en_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         oor_q   <= oor_d;
         to_q    <= to_d;
      end
   end

   always_comb begin
      state_d = state_q;
      rr_d    = rr_q;
      owner_d = owner_q;
      cnt_d   = cnt_q;
      // a timed-out owner may relock only after dropping lock once
      blk_d   = blk_q & lock;
      to_d    = 1'b0;
      gnt_id  = REQ_NONE;
      sel     = REQ_NONE;
      cand    = rr_q;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (sel == REQ_NONE && |(req & id_onehot(cand))) begin
            sel = cand;
         end
         cand = rr_next(cand);
      end
      unique case (state_q)
         ARB: begin
            if (sel != REQ_NONE) begin
               gnt_id = sel;
               rr_d   = rr_next(sel);
               if (|(lock & ~blk_q & id_onehot(sel))) begin
                  state_d = LOCKED;
                  owner_d = sel;
                  cnt_d   = '0;
               end
            end
         end
         LOCKED: begin
            if (|(req & id_onehot(owner_q))) begin
               gnt_id = owner_q;
            end
            cnt_d = cnt_q + 1'b1;
            if (!(|(lock & id_onehot(owner_q)))) begin
               state_d = ARB;
               owner_d = REQ_NONE;
            end else if (cnt_q == CNT_W'(LOCK_MAX)) begin
               state_d = ARB;
               owner_d = REQ_NONE;
               to_d    = 1'b1;
               blk_d   = blk_d | id_onehot(owner_q);
            end
         end
         default: begin
            state_d = ARB;
         end
      endcase
   end

   always_comb begin
      sel_addr  = '0;
      sel_wdata = '0;
      sel_we    = 1'b0;
      unique case (gnt_id)
         REQ_IN: begin
            sel_addr  = bus.addr_in;
            sel_wdata = bus.wdata_in;
            sel_we    = bus.we_in;
         end
         REQ_DISP: begin
            sel_addr  = bus.addr_disp;
         end
         REQ_CALC: begin
            sel_addr  = bus.addr_calc;
            sel_wdata = bus.wdata_calc;
            sel_we    = bus.we_calc;
         end
         default: begin
            sel_addr  = '0;
         end
      endcase
      gnt_d   = id_onehot(gnt_id);
      oor_d   = (gnt_id != REQ_NONE) &&
                (32'(sel_addr) >= MEM_DEPTH);
      en_d    = (gnt_id != REQ_NONE) && !oor_d;
      we_d    = en_d && sel_we;
      addr_d  = en_d ? sel_addr : addr_q;
      wdata_d = we_d ? sel_wdata : wdata_q;
      push    = en_d && !sel_we;
   end

   mem_arb_rd_tag_pipe #(
      .RD_LAT (RD_LAT),
      .DATA_W (DATA_W)
   ) u_tag_pipe (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .push_id   (gnt_id),
      .mem_rdata (bus.mem_rdata),
      .rvalid    (rvalid),
      .rdata     (bus.rdata)
   );

   assign bus.gnt_in      = gnt_q[0];
   assign bus.gnt_disp    = gnt_q[1];
   assign bus.gnt_calc    = gnt_q[2];
   assign bus.rvalid_in   = rvalid[0];
   assign bus.rvalid_disp = rvalid[1];
   assign bus.rvalid_calc = rvalid[2];
   assign bus.mem_en      = en_q;
   assign bus.mem_we      = we_q;
   assign bus.mem_addr    = addr_q;
   assign bus.mem_wdata   = wdata_q;
   assign bus.err_oor     = oor_q;
   assign bus.err_lock_to = to_q;
   assign bus.arb_owner   = owner_q;

endmodule

// File: tb/tb_matrix_mem_arbiter.sv
// Bench for matrix_mem_arbiter: RAM model, reference memory, read
// scoreboard fed at grant time and drained on rvalid.
module tb_matrix_mem_arbiter;
   import mem_arb_pkg::*;

   localparam int ADDR_W    = 8;
   localparam int DATA_W    = 32;
   localparam int MEM_DEPTH = 200;
   localparam int RD_LAT    = 1;
   localparam int LOCK_MAX  = 1023;

   typedef struct {
      logic [1:0]  id;
      logic [31:0] data;
      int          gcyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [2:0]  req, we, lock, hold;
   logic [7:0]  addr [3];
   logic [31:0] wdata [3];
   logic [31:0] ref_mem [256];
   exp_t        sb [$];
   logic [2:0]  gnt;

   matrix_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   matrix_mem_arbiter #(
      .ADDR_W    (ADDR_W),
      .DATA_W    (DATA_W),
      .MEM_DEPTH (MEM_DEPTH),
      .RD_LAT    (RD_LAT),
      .LOCK_MAX  (LOCK_MAX)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   assign bus.req_in     = req[0];
   assign bus.req_disp   = req[1];
   assign bus.req_calc   = req[2];
   assign bus.we_in      = we[0];
   assign bus.we_disp    = we[1];
   assign bus.we_calc    = we[2];
   assign bus.addr_in    = addr[0];
   assign bus.addr_disp  = addr[1];
   assign bus.addr_calc  = addr[2];
   assign bus.wdata_in   = wdata[0];
   assign bus.wdata_calc = wdata[2];
   assign bus.lock_in    = lock[0];
   assign bus.lock_disp  = lock[1];
   assign bus.lock_calc  = lock[2];
   assign gnt = {bus.gnt_calc, bus.gnt_disp, bus.gnt_in};

   function automatic logic [31:0] init_word(input int i);
      return 32'h5A00_0000 | (i * 32'h0001_0101);
   endfunction

   // synchronous RAM model with RD_LAT cycles of read latency
   logic [31:0] ram [256];
   logic [31:0] ram_q [RD_LAT];
   bit ram_init = 1'b0;
   assign bus.mem_rdata = ram_q[RD_LAT-1];

   always @(posedge clk) begin
      if (!ram_init) begin
         for (int i = 0; i < 256; i++) ram[i] <= init_word(i);
         ram_init <= 1'b1;
      end else if (bus.mem_en) begin
         if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
         else ram_q[0] <= ram[bus.mem_addr];
      end
      for (int i = 1; i < RD_LAT; i++) ram_q[i] <= ram_q[i-1];
   end

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      logic [2:0] rv;
      exp_t e;
      rv = {bus.rvalid_calc, bus.rvalid_disp, bus.rvalid_in};
      if (rv != 3'b000) begin
         if (sb.size() == 0) begin
            check("rv_unexpected", 32'(rv), 32'd0);
         end else begin
            e = sb.pop_front();
            check("rv_id", 32'(rv), 32'(3'b001 << e.id));
            check("rdata", bus.rdata, e.data);
            check("rv_lat", cyc - e.gcyc, RD_LAT + 1);
         end
      end
   end

   task automatic grant_seen(input int r);
      logic oor, rd;
      oor = (int'(addr[r]) >= MEM_DEPTH);
      rd  = (r == 1) || !we[r];
      check("gnt_req", 32'(req[r]), 32'd1);
      check("gnt_onehot", 32'($onehot(gnt)), 32'd1);
      check("err_oor", 32'(bus.err_oor), 32'(oor));
      check("mem_en", 32'(bus.mem_en), 32'(!oor));
      if (!oor) begin
         check("mem_we", 32'(bus.mem_we), 32'(!rd));
         check("mem_addr", 32'(bus.mem_addr), 32'(addr[r]));
         if (rd) begin
            sb.push_back('{id: 2'(r), data: ref_mem[addr[r]], gcyc: cyc});
         end else begin
            check("mem_wdata", bus.mem_wdata, wdata[r]);
            ref_mem[addr[r]] = wdata[r];
         end
      end
      if (!hold[r]) req[r] = 1'b0;
   endtask

   task automatic tick();
      @(negedge clk);
      if (gnt == 3'b000) check("idle_mem_en", 32'(bus.mem_en), 32'd0);
      for (int r = 0; r < 3; r++) begin
         if (gnt[r]) grant_seen(r);
      end
   endtask

   task automatic wait_gnt(input int r, input int max);
      int n;
      n = 0;
      do begin
         tick();
         n++;
      end while (!gnt[r] && n < max);
      check($sformatf("gnt%0d_seen", r), 32'(gnt[r]), 32'd1);
   endtask

   task automatic chk_reset();
      check("rst_gnt", 32'(gnt), 32'd0);
      check("rst_rvalid", 32'({bus.rvalid_calc, bus.rvalid_disp,
                               bus.rvalid_in}), 32'd0);
      check("rst_mem_en", 32'(bus.mem_en), 32'd0);
      check("rst_mem_we", 32'(bus.mem_we), 32'd0);
      check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
      check("rst_mem_wdata", bus.mem_wdata, 32'd0);
      check("rst_rdata", bus.rdata, 32'd0);
      check("rst_err", 32'({bus.err_oor, bus.err_lock_to}), 32'd0);
      check("rst_owner", 32'(bus.arb_owner), 32'd3);
   endtask

   int n_to, to_at, gin_at;

   initial begin
      req = '0; we = '0; lock = '0; hold = '0;
      for (int i = 0; i < 3; i++) begin
         addr[i] = '0;
         wdata[i] = '0;
      end
      for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);

      tick();
      tick();
      chk_reset();
      rst_n = 1'b1;

      // three reads at once: round-robin from requester in
      req = 3'b111;
      addr[0] = 8'd5; addr[1] = 8'd6; addr[2] = 8'd7;
      tick(); check("t1_gnt_a", 32'(gnt), 32'b001);
      tick(); check("t1_gnt_b", 32'(gnt), 32'b010);
      tick(); check("t1_gnt_c", 32'(gnt), 32'b100);
      repeat (4) tick();

      // calc write then display read (display we=1 acts as read)
      req[2] = 1'b1; we[2] = 1'b1;
      addr[2] = 8'h40; wdata[2] = 32'hDEAD_BEEF;
      wait_gnt(2, 5);
      req[1] = 1'b1; we[1] = 1'b1; addr[1] = 8'h40;
      wait_gnt(1, 5);
      repeat (4) tick();
      check("t2_rdata", bus.rdata, 32'hDEAD_BEEF);
      we[1] = 1'b0; we[2] = 1'b0;

      // calc locked burst of 4 writes while in waits
      req[0] = 1'b1; we[0] = 1'b0; addr[0] = 8'h81;
      req[2] = 1'b1; we[2] = 1'b1; lock[2] = 1'b1; hold[2] = 1'b1;
      addr[2] = 8'h80; wdata[2] = 32'h1000;
      for (int k = 0; k < 4; k++) begin
         tick();
         check("t3_gnt", 32'(gnt), 32'b100);
         check("t3_owner", 32'(bus.arb_owner), 32'd2);
         addr[2] = addr[2] + 8'd1;
         wdata[2] = wdata[2] + 32'd1;
      end
      req[2] = 1'b0; lock[2] = 1'b0; hold[2] = 1'b0;
      tick(); check("t3_release", 32'(gnt), 32'b000);
      tick(); check("t3_gnt_in", 32'(gnt), 32'b001);
      check("t3_owner_free", 32'(bus.arb_owner), 32'd3);
      repeat (4) tick();

      // display lock held past LOCK_MAX
      req[1] = 1'b1; addr[1] = 8'd20; lock[1] = 1'b1;
      req[0] = 1'b1; addr[0] = 8'd21;
      tick(); check("t4_gnt_disp", 32'(gnt), 32'b010);
      n_to = 0; to_at = 0; gin_at = 0;
      for (int i = 1; i <= LOCK_MAX + 4; i++) begin
         tick();
         if (bus.err_lock_to) begin
            n_to++;
            to_at = i;
         end
         if (gnt[0] && gin_at == 0) gin_at = i;
         if (i == 10) check("t4_owner", 32'(bus.arb_owner), 32'd1);
         if (i == LOCK_MAX + 2) lock[1] = 1'b0;
      end
      check("t4_to_count", n_to, 1);
      check("t4_to_at", to_at, LOCK_MAX + 1);
      check("t4_gnt_in_at", gin_at, LOCK_MAX + 2);
      repeat (4) tick();

      // out-of-range read is granted but dropped
      req[0] = 1'b1; addr[0] = 8'd210;
      wait_gnt(0, 5);
      repeat (4) tick();

      // reset one cycle after a read grant
      req[0] = 1'b1; addr[0] = 8'd3;
      wait_gnt(0, 5);
      tick();
      rst_n = 1'b0;
      sb.delete();
      req[0] = 1'b1; req[1] = 1'b1;
      addr[0] = 8'd4; addr[1] = 8'd9;
      tick();
      tick();
      chk_reset();
      rst_n = 1'b1;
      tick(); check("t6_gnt_in", 32'(gnt), 32'b001);
      wait_gnt(1, 5);
      repeat (5) tick();
      check("sb_empty", sb.size(), 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
